// File: rtl/hazard_pkg.sv
// Shared lane codes, object state encoding and row width for the hazard tracker.
package hazard_pkg;

    localparam int unsigned Y_W = 10;

    localparam logic [1:0] RELEASE_NULL = 2'b00;
    localparam logic [1:0] ON_LEFT      = 2'b01;
    localparam logic [1:0] ON_MID       = 2'b10;
    localparam logic [1:0] ON_RIGHT     = 2'b11;

    typedef enum logic {
        OBJ_IDLE,
        OBJ_FALLING
    } obj_state_t;

endpackage

// File: rtl/hazard_object.sv
// One falling sprite: release edge detect, IDLE/FALLING state, row counter
// and the player hit-window compare against the registered row.
module hazard_object
    import hazard_pkg::*;
#(
    parameter int unsigned SPAWN_Y  = 0,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned HIT_Y    = 400,
    parameter int unsigned HIT_H    = 16,
    parameter int unsigned BOTTOM_Y = 479
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     rel_lane,
    input  logic [1:0]     player_lane,
    input  logic           consume,
    input  logic           kill,
    output logic           active,
    output logic [1:0]     lane,
    output logic [Y_W-1:0] y,
    output logic           in_window_c
);

    localparam int unsigned YW1 = Y_W + 1;

    obj_state_t     state;
    logic [1:0]     prev_rel;
    logic           spawn_c;
    logic           exit_c;
    logic [YW1-1:0] y_sum_c;

    // A new non-null lane code (relative to the last sampled one) releases the object.
    assign spawn_c = (rel_lane != prev_rel) && (rel_lane != RELEASE_NULL);

    // Next row computed one bit wider so the bottom test never wraps.
    assign y_sum_c = {1'b0, y} + YW1'(SPEED);
    assign exit_c  = y_sum_c > YW1'(BOTTOM_Y);

    assign active = (state == OBJ_FALLING);

    // Player overlap: visible, inside the hit rows, and in the player's (non-null) lane.
    assign in_window_c = active
                      && ({1'b0, y} >= YW1'(HIT_Y))
                      && ({1'b0, y} <  YW1'(HIT_Y + HIT_H))
                      && (lane == player_lane)
                      && (player_lane != RELEASE_NULL);

    // Object FSM and row counter; kill beats spawn, spawn beats hit/exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OBJ_IDLE;
            lane     <= RELEASE_NULL;
            y        <= Y_W'(SPAWN_Y);
            prev_rel <= RELEASE_NULL;
        end else if (en) begin
            prev_rel <= rel_lane;
            if (kill) begin
                state <= OBJ_IDLE;
            end else if (spawn_c) begin
                state <= OBJ_FALLING;
                lane  <= rel_lane;
                y     <= Y_W'(SPAWN_Y);
            end else if (state == OBJ_FALLING) begin
                if (consume || exit_c) begin
                    state <= OBJ_IDLE;
                end else begin
                    y <= y_sum_c[Y_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Coin/barrier sprite tracker: spawns on lane releases, scrolls once per frame,
// scores coin catches, charges lives on unjumped barrier hits, and flags game over.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned SPAWN_Y     = 0,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned HIT_Y       = 400,
    parameter int unsigned HIT_H       = 16,
    parameter int unsigned BOTTOM_Y    = 479,
    parameter int unsigned START_LIVES = 3
) (
    input  logic           i_v_sync,
    input  logic           i_rst,
    input  logic           GAME_SWITCH,
    input  logic [1:0]     RELEASE_COIN,
    input  logic [1:0]     RELEASE_BARRIER,
    input  logic [1:0]     PLAYER_LANE,
    input  logic           PLAYER_JUMP,
    output logic           COIN_ACTIVE,
    output logic [1:0]     COIN_LANE,
    output logic [Y_W-1:0] COIN_Y,
    output logic           BARRIER_ACTIVE,
    output logic [1:0]     BARRIER_LANE,
    output logic [Y_W-1:0] BARRIER_Y,
    output logic [7:0]     COIN_COUNT,
    output logic [1:0]     LIVES,
    output logic           ZERO_LIVES
);

    logic coin_win_c;
    logic bar_win_c;
    logic coin_hit_c;
    logic bar_hit_c;
    logic last_life_c;
    logic kill_c;

    // Barriers only connect while the player is on the ground.
    assign coin_hit_c = coin_win_c;
    assign bar_hit_c  = bar_win_c && !PLAYER_JUMP;

    assign ZERO_LIVES = (LIVES == 2'd0);

    // Clear both sprites on the same edge that the last life is lost, and keep them clear after.
    assign last_life_c = bar_hit_c && (LIVES == 2'd1);
    assign kill_c      = ZERO_LIVES || last_life_c;

    hazard_object #(
        .SPAWN_Y  (SPAWN_Y),
        .SPEED    (SPEED),
        .HIT_Y    (HIT_Y),
        .HIT_H    (HIT_H),
        .BOTTOM_Y (BOTTOM_Y)
    ) u_coin (
        .clk         (i_v_sync),
        .rst         (i_rst),
        .en          (GAME_SWITCH),
        .rel_lane    (RELEASE_COIN),
        .player_lane (PLAYER_LANE),
        .consume     (coin_hit_c),
        .kill        (kill_c),
        .active      (COIN_ACTIVE),
        .lane        (COIN_LANE),
        .y           (COIN_Y),
        .in_window_c (coin_win_c)
    );

    hazard_object #(
        .SPAWN_Y  (SPAWN_Y),
        .SPEED    (SPEED),
        .HIT_Y    (HIT_Y),
        .HIT_H    (HIT_H),
        .BOTTOM_Y (BOTTOM_Y)
    ) u_barrier (
        .clk         (i_v_sync),
        .rst         (i_rst),
        .en          (GAME_SWITCH),
        .rel_lane    (RELEASE_BARRIER),
        .player_lane (PLAYER_LANE),
        .consume     (bar_hit_c),
        .kill        (kill_c),
        .active      (BARRIER_ACTIVE),
        .lane        (BARRIER_LANE),
        .y           (BARRIER_Y),
        .in_window_c (bar_win_c)
    );

    // Score and lives; both freeze on pause and once the game is over.
    always_ff @(posedge i_v_sync) begin
        if (i_rst) begin
            COIN_COUNT <= 8'd0;
            LIVES      <= 2'(START_LIVES);
        end else if (GAME_SWITCH && !ZERO_LIVES) begin
            if (coin_hit_c && (COIN_COUNT != 8'hFF)) begin
                COIN_COUNT <= COIN_COUNT + 8'd1;
            end
            if (bar_hit_c) begin
                LIVES <= LIVES - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios plus random play, every frame
// compared against a frame-level behavioural model of the game rules.
module tb_hazard_tracker;

    localparam int SPAWN_Y  = 0;
    localparam int SPEED    = 2;
    localparam int HIT_Y    = 400;
    localparam int HIT_H    = 16;
    localparam int BOTTOM_Y = 479;
    localparam int START_L  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       gs;
    logic [1:0] rel_coin;
    logic [1:0] rel_bar;
    logic [1:0] pl;
    logic       jump;

    logic       coin_active;
    logic [1:0] coin_lane;
    logic [9:0] coin_y;
    logic       bar_active;
    logic [1:0] bar_lane;
    logic [9:0] bar_y;
    logic [7:0] coin_count;
    logic [1:0] lives;
    logic       zero_lives;

    int n_checks = 0;
    int n_errors = 0;

    // Model: index 0 = coin, 1 = barrier.
    int m_act[2];
    int m_lane[2];
    int m_y[2];
    int m_prev[2];
    int m_count;
    int m_lives;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .i_v_sync        (clk),
        .i_rst           (rst),
        .GAME_SWITCH     (gs),
        .RELEASE_COIN    (rel_coin),
        .RELEASE_BARRIER (rel_bar),
        .PLAYER_LANE     (pl),
        .PLAYER_JUMP     (jump),
        .COIN_ACTIVE     (coin_active),
        .COIN_LANE       (coin_lane),
        .COIN_Y          (coin_y),
        .BARRIER_ACTIVE  (bar_active),
        .BARRIER_LANE    (bar_lane),
        .BARRIER_Y       (bar_y),
        .COIN_COUNT      (coin_count),
        .LIVES           (lives),
        .ZERO_LIVES      (zero_lives)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One frame of the game rules, applied to the inputs sampled at this edge.
    task automatic model_step();
        int hit[2];
        int rel;
        int lives_after;
        bit over;
        bit kill;
        bit in_win;
        if (rst) begin
            for (int o = 0; o < 2; o++) begin
                m_act[o] = 0; m_lane[o] = 0; m_y[o] = SPAWN_Y; m_prev[o] = 0;
            end
            m_count = 0;
            m_lives = START_L;
        end else if (gs) begin
            over = (m_lives == 0);
            for (int o = 0; o < 2; o++) begin
                in_win = (m_act[o] != 0) && (m_lane[o] == int'(pl)) && (pl != 2'd0)
                      && (m_y[o] >= HIT_Y) && (m_y[o] < HIT_Y + HIT_H);
                hit[o] = in_win ? 1 : 0;
            end
            if (jump) hit[1] = 0;
            lives_after = m_lives;
            if (!over) begin
                if (hit[0] != 0 && m_count < 255) m_count++;
                if (hit[1] != 0) lives_after--;
            end
            m_lives = lives_after;
            kill = over || (lives_after == 0);
            for (int o = 0; o < 2; o++) begin
                rel = (o == 0) ? int'(rel_coin) : int'(rel_bar);
                if (kill) begin
                    m_act[o] = 0;
                end else if (rel != m_prev[o] && rel != 0) begin
                    m_act[o] = 1; m_y[o] = SPAWN_Y; m_lane[o] = rel;
                end else if (m_act[o] != 0) begin
                    if (hit[o] != 0 || m_y[o] + SPEED > BOTTOM_Y) m_act[o] = 0;
                    else m_y[o] = m_y[o] + SPEED;
                end
                m_prev[o] = rel;
            end
        end
    endtask

    task automatic check_all();
        chk("coin_active", 32'(coin_active), 32'(m_act[0]));
        chk("coin_lane",   32'(coin_lane),   32'(m_lane[0]));
        chk("coin_y",      32'(coin_y),      32'(m_y[0]));
        chk("bar_active",  32'(bar_active),  32'(m_act[1]));
        chk("bar_lane",    32'(bar_lane),    32'(m_lane[1]));
        chk("bar_y",       32'(bar_y),       32'(m_y[1]));
        chk("coin_count",  32'(coin_count),  32'(m_count));
        chk("lives",       32'(lives),       32'(m_lives));
        chk("zero_lives",  32'(zero_lives),  32'(m_lives == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_y(input bit is_bar, input int target, input string tag);
        int n = 0;
        while (((is_bar ? int'(bar_y) : int'(coin_y)) != target) && n < 600) begin
            tick();
            n++;
        end
        chk(tag, is_bar ? 32'(bar_y) : 32'(coin_y), 32'(target));
    endtask

    task automatic wait_idle(input bit is_bar, input string tag);
        int n = 0;
        while ((is_bar ? bar_active : coin_active) && n < 600) begin
            tick();
            n++;
        end
        chk(tag, is_bar ? 32'(bar_active) : 32'(coin_active), 32'd0);
    endtask

    initial begin
        rst = 1'b1; gs = 1'b1; rel_coin = 2'd0; rel_bar = 2'd0; pl = 2'd0; jump = 1'b0;

        // Reset state.
        do_reset();
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_count", 32'(coin_count), 32'd0);
        chk("rst_zero",  32'(zero_lives), 32'd0);
        chk("rst_coin_y", 32'(coin_y), 32'd0);

        // Coin catch in the middle lane.
        rel_coin = 2'b10; pl = 2'b10;
        tick();
        chk("catch_y0", 32'(coin_y), 32'd0);
        chk("catch_vis", 32'(coin_active), 32'd1);
        repeat (200) tick();
        chk("catch_y400", 32'(coin_y), 32'd400);
        tick();
        chk("catch_count", 32'(coin_count), 32'd1);
        chk("catch_gone", 32'(coin_active), 32'd0);

        // Barrier in another lane falls off the bottom.
        rel_bar = 2'b01; pl = 2'b11;
        tick();
        wait_y(1'b1, 478, "miss_y478");
        chk("miss_vis478", 32'(bar_active), 32'd1);
        tick();
        chk("miss_exit", 32'(bar_active), 32'd0);
        chk("miss_lives", 32'(lives), 32'd3);

        // Jump over a barrier for the whole window.
        rel_bar = 2'b10; pl = 2'b10; jump = 1'b1;
        tick();
        wait_idle(1'b1, "jump_pass");
        chk("jump_lives", 32'(lives), 32'd3);

        // Land in the middle of the window.
        rel_bar = 2'b00;
        tick();
        rel_bar = 2'b10;
        tick();
        wait_y(1'b1, 408, "land_y408");
        jump = 1'b0;
        tick();
        chk("land_lives", 32'(lives), 32'd2);
        chk("land_gone", 32'(bar_active), 32'd0);

        // Game over after three hits, then recover with reset.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rel_bar = 2'b00;
            tick();
            rel_bar = 2'b10; pl = 2'b10; jump = 1'b0;
            tick();
            wait_idle(1'b1, "over_hit");
            chk("over_lives", 32'(lives), 32'(2 - k));
        end
        chk("over_zero", 32'(zero_lives), 32'd1);
        rel_coin = 2'b11;
        tick();
        chk("over_nospawn", 32'(coin_active), 32'd0);
        chk("over_frozen", 32'(lives), 32'd0);
        do_reset();
        chk("over_rst_lives", 32'(lives), 32'd3);
        chk("over_rst_zero", 32'(zero_lives), 32'd0);

        // Pause holds the coin, then a lane change respawns it.
        rel_bar = 2'b00; rel_coin = 2'b10; pl = 2'b01;
        tick();
        wait_y(1'b0, 100, "pause_y100");
        gs = 1'b0;
        repeat (50) tick();
        chk("pause_hold", 32'(coin_y), 32'd100);
        gs = 1'b1; rel_coin = 2'b11;
        tick();
        chk("respawn_lane", 32'(coin_lane), 32'd3);
        chk("respawn_y", 32'(coin_y), 32'd0);

        // Saturate the coin count.
        do_reset();
        rel_bar = 2'b00;
        for (int k = 0; k < 256; k++) begin
            rel_coin = (k % 2 == 0) ? 2'b01 : 2'b10;
            pl = rel_coin;
            tick();
            wait_idle(1'b0, "sat_catch");
        end
        chk("sat_count", 32'(coin_count), 32'd255);

        // Random play.
        do_reset();
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(39, 0) == 0) rel_coin = 2'($urandom_range(3, 0));
            if ($urandom_range(39, 0) == 0) rel_bar  = 2'($urandom_range(3, 0));
            if ($urandom_range(19, 0) == 0) pl       = 2'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0)  jump     = ~jump;
            gs  = ($urandom_range(15, 0) != 0);
            rst = ($urandom_range(1999, 0) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Downstream consumer of the level state machine's RELEASE_COIN / RELEASE_BARRIER lane codes.
- Spawns one coin sprite and one barrier sprite, scrolls each down its lane once per frame, and resolves collisions against the player lane and jump state.
- Maintains the coin count and the lives count, and generates ZERO_LIVES, which is fed back to the state machine to force FINISH.
- Sits between the state machine and the sprite compositor / HUD.

Parameters:
- SPAWN_Y, 0: Y row at which a released object appears.
- SPEED, 2: rows advanced per frame while falling.
- HIT_Y, 400: top row of the player hit window.
- HIT_H, 16: hit window height; the window is HIT_Y <= y < HIT_Y+HIT_H.
- BOTTOM_Y, 479: last visible row.
- START_LIVES, 3: lives loaded at reset; must be 1..3.

Ports:
- i_v_sync  in  1  Clock; one rising edge per frame.
- i_rst  in  1  Synchronous, active-high reset.
- GAME_SWITCH  in  1  0 = pause; all registers hold.
- RELEASE_COIN  in  2  Lane code: 00 null, 01 left, 10 mid, 11 right.
- RELEASE_BARRIER  in  2  Lane code, same encoding as RELEASE_COIN.
- PLAYER_LANE  in  2  Current player lane (01/10/11; 00 never collides).
- PLAYER_JUMP  in  1  1 = player airborne; barriers pass under.
- COIN_ACTIVE  out  1  Coin sprite visible.
- COIN_LANE  out  2  Coin lane.
- COIN_Y  out  10  Coin row.
- BARRIER_ACTIVE  out  1  Barrier sprite visible.
- BARRIER_LANE  out  2  Barrier lane.
- BARRIER_Y  out  10  Barrier row.
- COIN_COUNT  out  8  Coins collected, saturating at 255.
- LIVES  out  2  Remaining lives.
- ZERO_LIVES  out  1  Combinational from the LIVES register: LIVES==0.

Behaviour:
- Reset values:
  - All *_ACTIVE=0, *_LANE=00, *_Y=SPAWN_Y.
  - COIN_COUNT=0, LIVES=START_LIVES, ZERO_LIVES=0.
  - Previous-release registers = 00.
- Reset has priority over everything, including mid-fall objects and ZERO_LIVES.
- Pause: with GAME_SWITCH=0, all state holds and previous-release registers do not update, so a release changing during pause is detected on resume.
- Release detection, per object: spawn when RELEASE != prev_release and RELEASE != 00.
  - A change to 00 does not despawn.
  - A direct change lane A -> lane B respawns at lane B.
  - On the spawn edge: object enters FALLING, Y=SPAWN_Y, LANE=RELEASE, visible the cycle after sampling.
- Per-object FSM (two states):
  - IDLE -> FALLING on spawn.
  - FALLING: Y += SPEED each cycle.
  - FALLING -> IDLE when Y+SPEED > BOTTOM_Y (the sum is computed 11 bits wide; no wrap).
  - FALLING -> IDLE on a consuming hit.
  - Spawn while FALLING restarts the object and takes priority over a hit or exit in the same cycle.
- Hit test, per cycle, uses the registered Y:
  - in_window = (HIT_Y <= Y < HIT_Y+HIT_H) and LANE == PLAYER_LANE and PLAYER_LANE != 00.
- Coin hit:
  - COIN_COUNT+1 next cycle, saturating at 255.
  - Coin goes to IDLE next cycle; exactly one increment per coin.
- Barrier hit: in_window and PLAYER_JUMP=0.
  - LIVES-1 next cycle; barrier goes to IDLE.
  - If jumping, the barrier keeps falling and is tested again on each following in-window cycle.
- LIVES never underflows.
- Game over: once LIVES==0, ZERO_LIVES=1 and is sticky until reset.
  - Both objects are forced IDLE the same cycle.
  - Spawns are ignored, and COIN_COUNT and LIVES freeze.
- Coin and barrier hits in the same cycle are both applied.
- Latency:
  - Release to visible: 1 cycle.
  - Hit to count/lives update: 1 cycle.
  - LIVES to ZERO_LIVES: 0 cycles.

Decomposition:
- Package hazard_pkg holds:
  - Lane localparams: RELEASE_NULL, ON_LEFT, ON_MID, ON_RIGHT.
  - obj_state_t enum {OBJ_IDLE, OBJ_FALLING}.
  - Y width constant (10).
- Sub-module hazard_object, instantiated twice (coin, barrier):
  - Owns the release edge detect, the FSM, the Y counter and the in_window compare.
  - Takes a consume input and a kill input; outputs active, lane, y and in_window.
- The top level owns COIN_COUNT, LIVES, the jump qualification for barriers, and game-over.

Test Plan:
- Coin catch: reset; RELEASE_COIN=10 at cycle 0, PLAYER_LANE=10 -> COIN_Y=0 at cycle 1, COIN_Y=400 at cycle 201, COIN_COUNT=1 and COIN_ACTIVE=0 at cycle 202.
- Barrier miss by lane: RELEASE_BARRIER=01, PLAYER_LANE=11 -> LIVES stays 3; BARRIER_ACTIVE falls at Y=478 (the cycle after Y=478 would add to 480 > 479).
- Jump: barrier in lane 10, PLAYER_JUMP=1 for the whole window -> LIVES=3. Repeat with jump dropped at Y=408 -> LIVES=2 at the following cycle.
- Game over: three barrier hits -> LIVES 3,2,1,0; ZERO_LIVES=1 in the same cycle LIVES=0; a subsequent RELEASE_COIN change gives no spawn; i_rst -> LIVES=3, ZERO_LIVES=0.
- Pause and respawn: GAME_SWITCH=0 at COIN_Y=100 for 50 cycles -> Y holds at 100. Then RELEASE_COIN 10 -> 11 -> COIN_LANE=11, COIN_Y=0 the next cycle.
- Saturation: preload via 255 coin catches; a further catch leaves COIN_COUNT=255.
